// File: rtl/hyper_pkg.sv
// Shared types and constants for the hyper_req_queue front-end:
// FSM encoding, command entry layout (we|addr|wdata|be|len, 75 bits) and burst limit.
package hyper_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_BSY = 2'd2,
        RUN      = 2'd3
    } hyper_state_t;

    localparam int HYPER_MAX_BURST = 32;

    localparam int WE_W    = 1;
    localparam int ADDR_W  = 32;
    localparam int WDATA_W = 32;
    localparam int BE_W    = 4;
    localparam int LEN_W   = 6;

    localparam int LEN_LSB   = 0;
    localparam int BE_LSB    = LEN_LSB + LEN_W;
    localparam int WDATA_LSB = BE_LSB + BE_W;
    localparam int ADDR_LSB  = WDATA_LSB + WDATA_W;
    localparam int WE_LSB    = ADDR_LSB + ADDR_W;

    typedef struct packed {
        logic               we;
        logic [ADDR_W-1:0]  addr;
        logic [WDATA_W-1:0] wdata;
        logic [BE_W-1:0]    be;
        logic [LEN_W-1:0]   len;
    } hyper_cmd_t;

    localparam int CMD_W = WE_LSB + WE_W;
    localparam int RSP_W = 33;

    // A zero length means one dword; anything longer than a burst is cut to a burst.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len, input int max_burst);
        if (len == '0)
            return LEN_W'(1);
        if (int'(len) > max_burst)
            return LEN_W'(max_burst);
        return len;
    endfunction

endpackage

// File: rtl/hyper_sync_fifo.sv
// Synchronous show-ahead FIFO with registered full/empty and occupancy count.
// full resets high so the write port stays closed until the first clock after reset.
module hyper_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_next;

    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign count_next = count + CW'(do_push) - CW'(do_pop);
    assign dout       = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b1;
            empty  <= 1'b1;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/hyper_req_queue.sv
// Host-side command/response queue in front of hyper_xface.
// Optional HYPER_REQ_STATS_EN adds issued read/write counters.
//
// state    | meaning
// IDLE     | wait for a head command, idle controller and (reads) response credit
// ISSUE    | one-cycle rd/wr request, pop command, load burst counter and timer
// WAIT_BSY | wait for controller busy; give up and flag err_tmo on timeout
// RUN      | collect read strobes until busy drops
module hyper_req_queue
    import hyper_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 32,
    parameter int MAX_BURST = HYPER_MAX_BURST,
    parameter int BUSY_TMO  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_be,
    input  logic [5:0]  cmd_len,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        x_rd_req,
    output logic        x_wr_req,
    output logic [31:0] x_addr,
    output logic [31:0] x_wr_d,
    output logic [3:0]  x_wr_byte_en,
    output logic [5:0]  x_rd_num_dwords,
    input  logic        x_busy,
    input  logic        x_rd_rdy,
    input  logic [31:0] x_rd_d,
    output logic        err_tmo
`ifdef HYPER_REQ_STATS_EN
    ,
    output logic [31:0] stat_rd_cnt,
    output logic [31:0] stat_wr_cnt
`endif
);

    localparam int CCW = $clog2(CMD_DEPTH) + 1;
    localparam int RCW = $clog2(RSP_DEPTH) + 1;
    localparam int TW  = $clog2(BUSY_TMO) + 1;

    hyper_state_t     state, state_next;
    hyper_cmd_t       cmd_in, head;
    logic             cmd_full, cmd_empty, cmd_pop;
    logic [CCW-1:0]   cmd_count;
    logic             rsp_push, rsp_full, rsp_empty;
    logic [RCW-1:0]   rsp_count;
    logic [RSP_W-1:0] rsp_dout;
    logic [5:0]       head_len;
    logic             credit_ok, load_x, tmo_hit, cur_we;
    logic [5:0]       len_cnt;
    logic [TW-1:0]    tmr;
    logic             status_unused;

    assign cmd_in    = {cmd_we, cmd_addr, cmd_wdata, cmd_be, cmd_len};
    assign cmd_ready = !cmd_full;

    hyper_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid),
        .din   (cmd_in),
        .pop   (cmd_pop),
        .dout  (head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    hyper_sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rsp_push),
        .din   ({len_cnt == 6'd1, x_rd_d}),
        .pop   (rsp_ready),
        .dout  (rsp_dout),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    // Occupancy of the command queue and response full are informational only.
    assign status_unused = ^{cmd_count, rsp_full};

    assign head_len  = clamp_len(head.len, MAX_BURST);
    assign credit_ok = head.we || ((RSP_DEPTH - int'(rsp_count)) >= int'(head_len));
    assign tmo_hit   = (state == WAIT_BSY) && !x_busy && (tmr == '0);
    assign rsp_push  = (state == RUN) && !cur_we && x_rd_rdy && (len_cnt != '0);

    assign x_rd_req  = (state == ISSUE) && !cur_we;
    assign x_wr_req  = (state == ISSUE) && cur_we;
    assign rsp_valid = !rsp_empty;
    assign rsp_data  = rsp_valid ? rsp_dout[31:0] : 32'd0;
    assign rsp_last  = rsp_valid && rsp_dout[32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        cmd_pop    = 1'b0;
        load_x     = 1'b0;
        case (state)
            IDLE: begin
                if (!cmd_empty && !x_busy && credit_ok) begin
                    state_next = ISSUE;
                    load_x     = 1'b1;
                end
            end
            ISSUE: begin
                cmd_pop    = 1'b1;
                state_next = WAIT_BSY;
            end
            WAIT_BSY: begin
                if (x_busy)
                    state_next = RUN;
                else if (tmo_hit)
                    state_next = IDLE;
            end
            RUN: begin
                if (!x_busy)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Timer is loaded in ISSUE so the window counts from the request cycle itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_we          <= 1'b0;
            x_addr          <= '0;
            x_wr_d          <= '0;
            x_wr_byte_en    <= '0;
            x_rd_num_dwords <= '0;
            len_cnt         <= '0;
            tmr             <= '0;
            err_tmo         <= 1'b0;
        end else begin
            if (load_x) begin
                cur_we          <= head.we;
                x_addr          <= head.addr;
                x_wr_d          <= head.wdata;
                x_wr_byte_en    <= head.be;
                x_rd_num_dwords <= head_len;
            end
            if (state == ISSUE) begin
                len_cnt <= x_rd_num_dwords;
                tmr     <= TW'(BUSY_TMO - 2);
            end else begin
                if ((state == WAIT_BSY) && (tmr != '0))
                    tmr <= tmr - TW'(1);
                if (rsp_push)
                    len_cnt <= len_cnt - 6'd1;
            end
            if (tmo_hit)
                err_tmo <= 1'b1;
        end
    end

`ifdef HYPER_REQ_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_rd_cnt <= '0;
            stat_wr_cnt <= '0;
        end else begin
            if (x_rd_req)
                stat_rd_cnt <= stat_rd_cnt + 32'd1;
            if (x_wr_req)
                stat_wr_cnt <= stat_wr_cnt + 32'd1;
        end
    end
`endif

endmodule
